ahb_mem_arbiter: RTL

- 2-to-1 AHB-Lite arbiter that shares one single-port AHB memory slave between the core's instruction master (imem, M0) and data master (dmem, M1).
- Sits between the core's io_mem_imem_*/io_mem_dmem_* buses and a unified memory or peripheral slave.
- Adds no latency when there is no contention.
- On a collision, it buffers the losing master's address phase and replays it later, while holding that master's hready low.

---
 rtl/ahb_pkg.sv | 25 ++
 rtl/ahb_req_buffer.sv | 34 +++
 rtl/ahb_mem_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and record types for the memory arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Who owns the slave data phase this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    // Address-phase record at the default RV32 width. Other widths declare
    // the same layout locally and hand it to ahb_req_buffer as a type.
    typedef struct packed {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
    } addr_rec_t;

endpackage

// File: rtl/ahb_req_buffer.sv
// One-entry holding register for a master's address phase that lost
// arbitration. It presents either the held record or the live bus record.
module ahb_req_buffer
    import ahb_pkg::*;
#(
    parameter type rec_t = addr_rec_t
) (
    input  logic clk,
    input  logic resetn,
    input  logic set,
    input  logic clear,
    input  rec_t live_rec,
    output logic pend,
    output rec_t sel_rec
);

    rec_t pend_rec;

    // Capture a losing live request, and drop it once its replay is granted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend     <= 1'b0;
            pend_rec <= '0;
        end else if (set) begin
            pend     <= 1'b1;
            pend_rec <= live_rec;
        end else if (clear) begin
            pend     <= 1'b0;
        end
    end

    assign sel_rec = pend ? pend_rec : live_rec;

endmodule

// File: rtl/ahb_mem_arbiter.sv
// 2-to-1 AHB-Lite arbiter sharing one memory slave between the imem (M0)
// and dmem (M1) masters. dmem wins by default; imem is forced through after
// MAX_CONSEC back-to-back dmem wins. A loser's address phase is buffered and
// replayed while its hready is held low. XLen must be 32 or 64 and
// MAX_CONSEC must lie in 1..15.
module ahb_mem_arbiter
    import ahb_pkg::*;
#(
    parameter int XLen       = 32,
    parameter int MAX_CONSEC = 2
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic [1:0]      m0_htrans,
    input  logic [XLen-1:0] m0_haddr,
    input  logic            m0_hwrite,
    input  logic [2:0]      m0_hsize,
    input  logic [XLen-1:0] m0_hwdata,
    output logic [XLen-1:0] m0_hrdata,
    output logic            m0_hready,
    output logic            m0_hresp,

    input  logic [1:0]      m1_htrans,
    input  logic [XLen-1:0] m1_haddr,
    input  logic            m1_hwrite,
    input  logic [2:0]      m1_hsize,
    input  logic [XLen-1:0] m1_hwdata,
    output logic [XLen-1:0] m1_hrdata,
    output logic            m1_hready,
    output logic            m1_hresp,

    output logic [1:0]      s_htrans,
    output logic [XLen-1:0] s_haddr,
    output logic            s_hwrite,
    output logic [2:0]      s_hsize,
    output logic [XLen-1:0] s_hwdata,
    input  logic [XLen-1:0] s_hrdata,
    input  logic            s_hready,
    input  logic            s_hresp,

    output logic [1:0]      grant_o
);

    typedef struct packed {
        logic [XLen-1:0] haddr;
        logic            hwrite;
        logic [2:0]      hsize;
    } rec_t;

    localparam logic [3:0] DCNT_MAX = 4'(MAX_CONSEC);

    owner_e     dp_owner;
    logic [3:0] dcnt;

    logic live0, live1;
    logic req0, req1;
    logic pend0, pend1;
    logic gnt0, gnt1;
    logic set0, set1, clr0, clr1;
    rec_t live_rec0, live_rec1;
    rec_t sel_rec0, sel_rec1;

    // BUSY and SEQ are not recognised here, so they fall out as IDLE.
    assign live0 = (m0_htrans == HTRANS_NONSEQ) && m0_hready;
    assign live1 = (m1_htrans == HTRANS_NONSEQ) && m1_hready;
    assign req0  = pend0 || live0;
    assign req1  = pend1 || live1;

    assign live_rec0 = {m0_haddr, m0_hwrite, m0_hsize};
    assign live_rec1 = {m1_haddr, m1_hwrite, m1_hsize};

    assign set0 = s_hready && live0 && !gnt0;
    assign set1 = s_hready && live1 && !gnt1;
    assign clr0 = s_hready && gnt0;
    assign clr1 = s_hready && gnt1;

    ahb_req_buffer #(.rec_t(rec_t)) u_buf_m0 (
        .clk      (clk),
        .resetn   (resetn),
        .set      (set0),
        .clear    (clr0),
        .live_rec (live_rec0),
        .pend     (pend0),
        .sel_rec  (sel_rec0)
    );

    ahb_req_buffer #(.rec_t(rec_t)) u_buf_m1 (
        .clk      (clk),
        .resetn   (resetn),
        .set      (set1),
        .clear    (clr1),
        .live_rec (live_rec1),
        .pend     (pend1),
        .sel_rec  (sel_rec1)
    );

    // Pick the winner: dmem unless imem has waited out its consecutive-loss budget.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req1 && !(req0 && (dcnt == DCNT_MAX))) begin
            gnt1 = 1'b1;
        end else if (req0) begin
            gnt0 = 1'b1;
        end
    end

    assign grant_o = {gnt1, gnt0};

    // Drive the slave address phase from whichever source won.
    always_comb begin
        s_htrans = HTRANS_IDLE;
        s_haddr  = '0;
        s_hwrite = 1'b0;
        s_hsize  = 3'b000;
        if (gnt1) begin
            s_htrans = HTRANS_NONSEQ;
            s_haddr  = sel_rec1.haddr;
            s_hwrite = sel_rec1.hwrite;
            s_hsize  = sel_rec1.hsize;
        end else if (gnt0) begin
            s_htrans = HTRANS_NONSEQ;
            s_haddr  = sel_rec0.haddr;
            s_hwrite = sel_rec0.hwrite;
            s_hsize  = sel_rec0.hsize;
        end
    end

    // The accepted address phase becomes the next data phase; stalls hold it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dp_owner <= OWN_NONE;
        end else if (s_hready) begin
            if (gnt1) begin
                dp_owner <= OWN_M1;
            end else if (gnt0) begin
                dp_owner <= OWN_M0;
            end else begin
                dp_owner <= OWN_NONE;
            end
        end
    end

    // Count dmem wins taken while imem was waiting; any imem win starts over.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dcnt <= 4'd0;
        end else if (s_hready) begin
            if (gnt0) begin
                dcnt <= 4'd0;
            end else if (gnt1 && req0 && (dcnt != DCNT_MAX)) begin
                dcnt <= dcnt + 4'd1;
            end
        end
    end

    // Write data follows the data-phase owner; a stalled M0 keeps its hwdata steady.
    always_comb begin
        s_hwdata = '0;
        case (dp_owner)
            OWN_M0:  s_hwdata = m0_hwdata;
            OWN_M1:  s_hwdata = m1_hwdata;
            default: s_hwdata = '0;
        endcase
    end

    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    // Owner sees the slave; a master with a buffered request is stalled.
    always_comb begin
        m0_hready = 1'b1;
        m0_hresp  = HRESP_OKAY;
        m1_hready = 1'b1;
        m1_hresp  = HRESP_OKAY;
        if (dp_owner == OWN_M0) begin
            m0_hready = s_hready;
            m0_hresp  = s_hresp;
        end else if (pend0) begin
            m0_hready = 1'b0;
        end
        if (dp_owner == OWN_M1) begin
            m1_hready = s_hready;
            m1_hresp  = s_hresp;
        end else if (pend1) begin
            m1_hready = 1'b0;
        end
    end

endmodule
